// File: rtl/saida_serial_uc.sv
// Control unit for the serial transmitter: sequences character fetch, frame load,
// bit shifting with an internal baud tick, and end-of-message signalling.
module saida_serial_uc #(
  parameter int CLKS_PER_BIT = 434,
  parameter int N_CARACTERES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic       fim,
  output logic       proximo,
  output logic       carrega,
  output logic       desloca,
  output logic       conta,
  output logic       pronto,
  output logic       ocupado,
  output logic [3:0] db_estado
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int CHAR_W = $clog2(N_CARACTERES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [CHAR_W-1:0] CHAR_LAST = CHAR_W'(N_CARACTERES - 1);

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    PEDE         = 4'd1,
    CARREGA      = 4'd2,
    ESPERA       = 4'd3,
    DESLOCA      = 4'd4,
    TESTA        = 4'd5,
    ESPERA_FINAL = 4'd6,
    FINAL        = 4'd7
  } estado_t;

  estado_t            estado, prox_estado;
  logic [TICK_W-1:0]  tick_cnt;
  logic [CHAR_W-1:0]  char_cnt;
  logic               tick;
  logic               ultimo;

  assign tick   = (tick_cnt == TICK_LAST);
  assign ultimo = (char_cnt == CHAR_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= prox_estado;
  end

  always_comb begin
    prox_estado = estado;
    case (estado)
      INICIAL:      if (partida) prox_estado = PEDE;
      PEDE:         prox_estado = CARREGA;
      CARREGA:      prox_estado = ESPERA;
      ESPERA:       if (tick) prox_estado = DESLOCA;
      DESLOCA:      prox_estado = TESTA;
      TESTA:        prox_estado = fim ? ESPERA_FINAL : ESPERA;
      ESPERA_FINAL: if (tick) prox_estado = ultimo ? FINAL : PEDE;
      FINAL:        prox_estado = INICIAL;
      default:      prox_estado = INICIAL;
    endcase
  end

  // Loading 1 in CARREGA compensates for the cycle spent there, so the start
  // bit lasts a full bit period just like every following bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else begin
      case (estado)
        INICIAL:                             tick_cnt <= '0;
        CARREGA:                             tick_cnt <= TICK_W'(1);
        ESPERA, DESLOCA, TESTA, ESPERA_FINAL: tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        default:                             tick_cnt <= tick_cnt;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      char_cnt <= '0;
    end else if (estado == INICIAL && partida) begin
      char_cnt <= '0;
    end else if (estado == ESPERA_FINAL && tick && !ultimo) begin
      char_cnt <= char_cnt + 1'b1;
    end
  end

  always_comb begin
    proximo   = (estado == PEDE);
    carrega   = (estado == CARREGA);
    desloca   = (estado == DESLOCA);
    conta     = (estado == DESLOCA);
    pronto    = (estado == FINAL);
    ocupado   = (estado != INICIAL);
    db_estado = estado;
  end

endmodule

// File: tb/tb_saida_serial_uc.sv
// Scoreboard bench for saida_serial_uc with a small datapath model driving fim.
module tb_saida_serial_uc;

  logic       clock, reset, partida, fim;
  logic       proximo, carrega, desloca, conta, pronto, ocupado;
  logic [3:0] db_estado;

  saida_serial_uc #(.CLKS_PER_BIT(4), .N_CARACTERES(2)) dut (
    .clock(clock), .reset(reset), .partida(partida), .fim(fim),
    .proximo(proximo), .carrega(carrega), .desloca(desloca), .conta(conta),
    .pronto(pronto), .ocupado(ocupado), .db_estado(db_estado)
  );

  typedef struct {
    logic [4:0] mask;
    int         cyc;
  } exp_t;

  // mask bits: {conta, pronto, desloca, carrega, proximo}
  localparam logic [4:0] M_PROX = 5'b00001;
  localparam logic [4:0] M_CARR = 5'b00010;
  localparam logic [4:0] M_DESL = 5'b10100;
  localparam logic [4:0] M_PRON = 5'b01000;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;
  int   ncyc   = 0;
  int   base   = 0;
  int   dcount = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    ncyc++;
  end

  // Datapath model: fim rises after the 9th desloca, clears on carrega.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      fim    <= 1'b0;
      dcount <= 0;
    end else if (carrega) begin
      fim    <= 1'b0;
      dcount <= 0;
    end else if (desloca) begin
      dcount <= dcount + 1;
      if (dcount == 8) fim <= 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc - base);
    end
  endtask

  task automatic push(input logic [4:0] m, input int rel, input int b);
    exp_t e;
    e.mask = m;
    e.cyc  = b + rel;
    q.push_back(e);
  endtask

  task automatic push_msg(input int b);
    push(M_PROX, 1, b);
    push(M_CARR, 2, b);
    for (int k = 0; k < 9; k++) push(M_DESL, 6 + 4 * k, b);
    push(M_PROX, 42, b);
    push(M_CARR, 43, b);
    for (int k = 0; k < 9; k++) push(M_DESL, 47 + 4 * k, b);
    push(M_PRON, 83, b);
  endtask

  // Monitor: every pulse on the outputs must match the head of the queue.
  initial begin
    logic [4:0] m;
    exp_t       e;
    forever begin
      @(negedge clock);
      m = {conta, pronto, desloca, carrega, proximo};
      if (m != 5'b0) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", int'(m), 0);
        end else begin
          e = q.pop_front();
          check("pulse_kind", int'(m), int'(e.mask));
          check("pulse_cycle", ncyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int r;
    reset   = 1'b1;
    partida = 1'b0;
    #1 reset = 1'b0;

    repeat (3) begin
      @(negedge clock);
      check("rst_outputs", int'({proximo, carrega, desloca, conta, pronto, ocupado}), 0);
      check("rst_estado", int'(db_estado), 0);
    end
    reset = 1'b1;
    repeat (20) begin
      @(negedge clock);
      check("idle_estado", int'(db_estado), 0);
      check("idle_ocupado", int'(ocupado), 0);
    end

    // Two back-to-back messages: the held partida restarts only after FINAL.
    base    = ncyc;
    partida = 1'b1;
    push_msg(base);
    push_msg(base + 84);
    for (int i = 1; i <= 170; i++) begin
      @(negedge clock);
      r = ncyc - base;
      if (r == 1)  partida = 1'b0;
      if (r == 5)  partida = 1'b1;
      if (r == 90) partida = 1'b0;
      check("ocupado", int'(ocupado), ((r <= 83) || (r >= 85 && r <= 167)) ? 1 : 0);
      if (r == 40 || r == 41 || r == 81 || r == 82) check("espera_final", int'(db_estado), 6);
      if (r == 84) check("back_to_inicial", int'(db_estado), 0);
      if (r == 83) check("final_state", int'(db_estado), 7);
    end

    // Third message, interrupted by an asynchronous reset mid-frame.
    base    = ncyc;
    partida = 1'b1;
    push(M_PROX, 1, base);
    push(M_CARR, 2, base);
    for (int k = 0; k < 4; k++) push(M_DESL, 6 + 4 * k, base);
    for (int i = 1; i <= 19; i++) begin
      @(negedge clock);
      if (ncyc - base == 1) partida = 1'b0;
    end
    @(posedge clock);
    #1 check("pre_rst_estado", int'(db_estado), 3);
    check("pre_rst_ocupado", int'(ocupado), 1);
    #1 reset = 1'b0;
    #1 check("async_rst_estado", int'(db_estado), 0);
    check("async_rst_outputs", int'({proximo, carrega, desloca, conta, pronto, ocupado}), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (30) begin
      @(negedge clock);
      check("post_rst_estado", int'(db_estado), 0);
    end
    check("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
